// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer
//   Multi-channel PWM LED dimmer. A free-running period counter drives
//   CHANNELS PWM outputs. Each channel has debounced up/down buttons that
//   step a brightness level. Each level selects a geometrically spaced duty
//   threshold that is computed at elaboration.
//
//   Build option: LED_FADE_EN. When it is defined, the duty ramps toward the
//   target by at most FADE_STEP per period. When it is undefined, the duty
//   loads the target directly at the next period boundary.
//
// Ports
//   in_clk            system clock
//   in_rst_n          asynchronous active-low reset
//   in_btn_up         raw level-up buttons, one per channel (async, active high)
//   in_btn_down       raw level-down buttons, one per channel (async, active high)
//   out_led           registered PWM output per channel
//   out_level         current level per channel, channel i at [i*LVL_W +: LVL_W]
//   out_period_start  high for the cycle in which the period counter is 0
module led_pwm_dimmer #(
    parameter int CHANNELS          = 4,
    parameter int CNT_WIDTH         = 16,
    parameter int LEVELS            = 4,
    parameter int MIN_DUTY_PERMILLE = 100,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int FADE_STEP         = 256,
    localparam int LVL_W            = $clog2(LEVELS)
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic [CHANNELS-1:0]       in_btn_up,
    input  logic [CHANNELS-1:0]       in_btn_down,
    output logic [CHANNELS-1:0]       out_led,
    output logic [CHANNELS*LVL_W-1:0] out_level,
    output logic                      out_period_start
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);

    if (CHANNELS < 1 || LEVELS < 3 || DEBOUNCE_CYCLES < 1 || FADE_STEP < 1 ||
        MIN_DUTY_PERMILLE < 1 || MIN_DUTY_PERMILLE > 999) begin : g_bad_param
        $error("led_pwm_dimmer: parameter out of range");
    end

    // T(k) = floor(2^CNT_WIDTH * d^((LEVELS-1-k)/(LEVELS-2))), with the two
    // ends pinned to fully off and fully on.
    function automatic logic [CNT_WIDTH:0] thr_calc(input int k);
        real d;
        real e;
        real v;
        int  iv;
        logic [CNT_WIDTH:0] r;
        r = '0;
        if (k == LEVELS - 1) begin
            r[CNT_WIDTH] = 1'b1;
        end else if (k > 0) begin
            d = real'(MIN_DUTY_PERMILLE) / 1000.0;
            e = real'(LEVELS - 1 - k) / real'(LEVELS - 2);
            v = 1.0;
            for (int i = 0; i < CNT_WIDTH; i++) v = v * 2.0;
            v = v * (d ** e);
            iv = $rtoi(v);
            r = iv[CNT_WIDTH:0];
        end
        return r;
    endfunction

    logic [CNT_WIDTH:0] thr_tab [LEVELS];
    for (genvar k = 0; k < LEVELS; k++) begin : g_thr
        assign thr_tab[k] = thr_calc(k);
    end

`ifdef LED_FADE_EN
    localparam logic [CNT_WIDTH:0] FADE_V = (FADE_STEP > 2**CNT_WIDTH) ?
        (CNT_WIDTH+1)'(2**CNT_WIDTH) : (CNT_WIDTH+1)'(FADE_STEP);
`endif

    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_last;

    assign cnt_last = (cnt == '1);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt              <= '0;
            out_period_start <= 1'b0;
        end else begin
            cnt              <= cnt + CNT_WIDTH'(1);
            out_period_start <= cnt_last;
        end
    end

    // Buttons [CHANNELS-1:0] are the up buttons and [2*CHANNELS-1:CHANNELS]
    // are the down buttons.
    logic [2*CHANNELS-1:0] btn_raw;
    logic [2*CHANNELS-1:0] btn_press;

    assign btn_raw = {in_btn_down, in_btn_up};

    for (genvar b = 0; b < 2*CHANNELS; b++) begin : g_btn
        logic            sync1;
        logic            sync2;
        logic            stable;
        logic            press;
        logic [DB_W-1:0] db_cnt;

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                stable <= 1'b0;
                press  <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1 <= btn_raw[b];
                sync2 <= sync1;
                press <= 1'b0;
                if (sync2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync2;
                    press  <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign btn_press[b] = press;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic                 up_evt;
        logic                 dn_evt;
        logic [LVL_W-1:0]     level;
        logic [CNT_WIDTH:0]   duty;
        logic [CNT_WIDTH:0]   duty_next;
        logic                 led;

        assign up_evt = btn_press[c];
        assign dn_evt = btn_press[CHANNELS + c];

`ifdef LED_FADE_EN
        logic [CNT_WIDTH:0] target;
        logic [CNT_WIDTH:0] gap;

        always_comb begin
            target    = thr_tab[level];
            duty_next = target;
            gap       = '0;
            if (target > duty) begin
                gap = target - duty;
                if (gap > FADE_V) duty_next = duty + FADE_V;
            end else if (duty > target) begin
                gap = duty - target;
                if (gap > FADE_V) duty_next = duty - FADE_V;
            end
        end
`else
        assign duty_next = thr_tab[level];
`endif

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                level <= '0;
                duty  <= '0;
                led   <= 1'b0;
            end else begin
                if (up_evt && !dn_evt && level != LVL_MAX)
                    level <= level + LVL_W'(1);
                else if (dn_evt && !up_evt && level != '0)
                    level <= level - LVL_W'(1);
                // Duty only moves on the last count, so a period is never split.
                if (cnt_last)
                    duty <= duty_next;
                led <= ({1'b0, cnt} < duty);
            end
        end

        assign out_led[c]                    = led;
        assign out_level[c*LVL_W +: LVL_W]   = level;
    end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
module tb_led_pwm_dimmer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] up = 2'b00;
    logic [1:0] dn = 2'b00;
    logic [1:0] led;
    logic [3:0] lvl;
    logic       ps;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pwm_dimmer #(
        .CHANNELS(2), .CNT_WIDTH(8), .LEVELS(4), .MIN_DUTY_PERMILLE(100),
        .DEBOUNCE_CYCLES(4), .FADE_STEP(32)
    ) dut (
        .in_clk(clk),
        .in_rst_n(rst_n),
        .in_btn_up(up),
        .in_btn_down(dn),
        .out_led(led),
        .out_level(lvl),
        .out_period_start(ps)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        up = 2'b00;
        dn = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [1:0] u, input logic [1:0] d);
        @(negedge clk);
        up = u;
        dn = d;
        repeat (10) @(negedge clk);
        up = 2'b00;
        dn = 2'b00;
        repeat (10) @(negedge clk);
    endtask

    task automatic sync_period();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ps !== 1'b1 && k < 600);
        n_cmp++;
        if (ps !== 1'b1) begin
            n_bad++;
            $display("FAIL period_wait: period_start=%b after %0d cycles, required 1", ps, k);
        end
    endtask

    task automatic count_period(input int ch, output int h);
        h = 0;
        repeat (256) begin
            @(negedge clk);
            if (led[ch] === 1'b1) h++;
        end
    endtask

    task automatic test_reset();
        int first;
        int pulses;
        int led_hi;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({led, lvl, ps} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: led=%b level=%h ps=%b, required all 0", led, lvl, ps);
        end
        rst_n = 1'b1;
        first = -1;
        pulses = 0;
        led_hi = 0;
        for (int k = 1; k <= 768; k++) begin
            @(negedge clk);
            if (ps === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (led !== 2'b00) led_hi++;
        end
        n_cmp++;
        if (first !== 256) begin
            n_bad++;
            $display("FAIL first_period_start: at cycle %0d, required 256", first);
        end
        n_cmp++;
        if (pulses !== 3) begin
            n_bad++;
            $display("FAIL period_start_count: %0d pulses, required 3", pulses);
        end
        n_cmp++;
        if (led_hi !== 0 || lvl !== 4'd0) begin
            n_bad++;
            $display("FAIL idle_dark: led_hi_cycles=%0d level=%h, required 0 and 0", led_hi, lvl);
        end
    endtask

    task automatic test_step_duty();
        int h0;
        int h1;
        do_reset();
        press(2'b01, 2'b00);
        press(2'b01, 2'b00);
        n_cmp++;
        if (lvl !== 4'b0010) begin
            n_bad++;
            $display("FAIL two_ups: level=%b, required 0010", lvl);
        end
`ifndef LED_FADE_EN
        sync_period();
        sync_period();
        fork
            count_period(0, h0);
            count_period(1, h1);
        join
        n_cmp++;
        if (h0 !== 80) begin
            n_bad++;
            $display("FAIL duty_level2: ch0 high %0d, required 80", h0);
        end
        n_cmp++;
        if (h1 !== 0) begin
            n_bad++;
            $display("FAIL ch1_idle: ch1 high %0d, required 0", h1);
        end
        press(2'b00, 2'b01);
        sync_period();
        sync_period();
        count_period(0, h0);
        n_cmp++;
        if (h0 !== 25 || lvl !== 4'b0001) begin
            n_bad++;
            $display("FAIL duty_level1: high %0d level %b, required 25 and 0001", h0, lvl);
        end
`endif
    endtask

    task automatic test_saturate();
        int h;
        do_reset();
        repeat (5) press(2'b01, 2'b00);
        n_cmp++;
        if (lvl !== 4'b0011) begin
            n_bad++;
            $display("FAIL sat_top: level=%b, required 0011", lvl);
        end
`ifndef LED_FADE_EN
        sync_period();
        sync_period();
        count_period(0, h);
        n_cmp++;
        if (h !== 256) begin
            n_bad++;
            $display("FAIL full_on: high %0d, required 256", h);
        end
`endif
        repeat (5) press(2'b00, 2'b01);
        n_cmp++;
        if (lvl !== 4'b0000) begin
            n_bad++;
            $display("FAIL sat_bottom: level=%b, required 0000", lvl);
        end
`ifndef LED_FADE_EN
        sync_period();
        sync_period();
        count_period(0, h);
        n_cmp++;
        if (h !== 0) begin
            n_bad++;
            $display("FAIL full_off: high %0d, required 0", h);
        end
`endif
        press(2'b01, 2'b00);
        press(2'b01, 2'b01);
        n_cmp++;
        if (lvl !== 4'b0001) begin
            n_bad++;
            $display("FAIL up_and_down: level=%b, required 0001", lvl);
        end
        press(2'b10, 2'b00);
        n_cmp++;
        if (lvl !== 4'b0101) begin
            n_bad++;
            $display("FAIL ch1_up: level=%b, required 0101", lvl);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            up = 2'b01;
            repeat (3) @(negedge clk);
            up = 2'b00;
            @(negedge clk);
        end
        up = 2'b01;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (lvl !== 4'b0000) begin
            n_bad++;
            $display("FAIL bounce_early: level=%b, required 0000", lvl);
        end
        @(negedge clk);
        n_cmp++;
        if (lvl !== 4'b0001) begin
            n_bad++;
            $display("FAIL bounce_accept: level=%b, required 0001", lvl);
        end
        repeat (10) @(negedge clk);
        up = 2'b00;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (lvl !== 4'b0001) begin
            n_bad++;
            $display("FAIL bounce_single: level=%b, required 0001", lvl);
        end
    endtask

`ifdef LED_FADE_EN
    task automatic test_fade();
        int h;
        int exp_h;
        do_reset();
        sync_period();
        fork
            count_period(0, h);
            begin
                repeat (3) press(2'b01, 2'b00);
            end
        join
        n_cmp++;
        if (h !== 0) begin
            n_bad++;
            $display("FAIL fade_start: high %0d, required 0", h);
        end
        for (int p = 1; p <= 8; p++) begin
            count_period(0, h);
            exp_h = 32 * p;
            n_cmp++;
            if (h !== exp_h) begin
                n_bad++;
                $display("FAIL fade_up_%0d: high %0d, required %0d", p, h, exp_h);
            end
        end
        do_reset();
        sync_period();
        fork
            count_period(0, h);
            begin
                repeat (3) press(2'b01, 2'b00);
            end
        join
        count_period(0, h);
        count_period(0, h);
        count_period(0, h);
        n_cmp++;
        if (h !== 96) begin
            n_bad++;
            $display("FAIL fade_pre96: high %0d, required 96", h);
        end
        fork
            count_period(0, h);
            press(2'b00, 2'b01);
        join
        n_cmp++;
        if (h !== 128) begin
            n_bad++;
            $display("FAIL fade_128: high %0d, required 128", h);
        end
        count_period(0, h);
        n_cmp++;
        if (h !== 96) begin
            n_bad++;
            $display("FAIL fade_retarget_96: high %0d, required 96", h);
        end
        count_period(0, h);
        n_cmp++;
        if (h !== 80) begin
            n_bad++;
            $display("FAIL fade_retarget_80: high %0d, required 80", h);
        end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        repeat (3) press(2'b01, 2'b00);
        n_cmp++;
        if (lvl !== 4'b0011) begin
            n_bad++;
            $display("FAIL pre_reset_level: level=%b, required 0011", lvl);
        end
`ifndef LED_FADE_EN
        sync_period();
        sync_period();
        repeat (100) @(negedge clk);
        n_cmp++;
        if (led[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_led: led0=%b, required 1", led[0]);
        end
`else
        repeat (100) @(negedge clk);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (led !== 2'b00 || lvl !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_reset: led=%b level=%b, required 00 and 0000", led, lvl);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_step_duty();
        test_saturate();
        test_bounce();
`ifdef LED_FADE_EN
        test_fade();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
